// File: rtl/branch_resolve_unit.sv
// Branch resolution: carries D-stage branch info through E and M, detects
// mispredictions in M, kills the wrong path and keeps saturating statistics.
module branch_resolve_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallE,
  input  logic        stallM,
  input  logic        flushE,
  input  logic        branchD,
  input  logic        pred_takeD,
  input  logic [31:0] pcD,
  input  logic [31:0] branch_targetD,
  input  logic        actual_takeE,
  output logic        branchM,
  output logic        actual_takeM,
  output logic [31:0] pcM,
  output logic        pred_wrong,
  output logic        flush_pred,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  logic        branchE, pred_takeE;
  logic [31:0] pcE, targetE;
  logic        pred_takeM;
  logic [31:0] targetM;
  logic        kill, branch_inc;

  assign pred_wrong  = branchM & (pred_takeM != actual_takeM);
  assign kill        = pred_wrong & ~stallM;
  assign flush_pred  = kill;
  assign redirect_pc = actual_takeM ? targetM : pcM + 32'd8;
  // a stalled E feeds a bubble to M, so a branch is counted only on its real move
  assign branch_inc  = ~stallM & ~kill & ~stallE & branchE;

  // D -> E
  always_ff @(posedge clk) begin
    if (rst) begin
      branchE    <= 1'b0;
      pred_takeE <= 1'b0;
      pcE        <= RESET_PC;
      targetE    <= '0;
    end else if (kill || flushE) begin
      branchE    <= 1'b0;
      pred_takeE <= 1'b0;
    end else if (!stallE) begin
      branchE    <= branchD;
      pred_takeE <= pred_takeD;
      pcE        <= pcD;
      targetE    <= branch_targetD;
    end
  end

  // E -> M
  always_ff @(posedge clk) begin
    if (rst) begin
      branchM      <= 1'b0;
      pred_takeM   <= 1'b0;
      actual_takeM <= 1'b0;
      pcM          <= RESET_PC;
      targetM      <= '0;
    end else if (kill || (!stallM && stallE)) begin
      branchM      <= 1'b0;
      pred_takeM   <= 1'b0;
      actual_takeM <= 1'b0;
    end else if (!stallM) begin
      branchM      <= branchE;
      pred_takeM   <= pred_takeE;
      actual_takeM <= actual_takeE;
      pcM          <= pcE;
      targetM      <= targetE;
    end
  end

  // saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (branch_inc && branch_cnt != 32'hFFFF_FFFF) branch_cnt <= branch_cnt + 32'd1;
      if (kill && mispred_cnt != 32'hFFFF_FFFF) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: pipeline timing, redirects, stalls,
// kill priority, counter saturation and reset.
module tb_branch_resolve_unit;
  localparam logic [31:0] RPC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst, stallE, stallM, flushE, branchD, pred_takeD, actual_takeE;
  logic [31:0] pcD, branch_targetD;
  logic        branchM, actual_takeM, pred_wrong, flush_pred;
  logic [31:0] pcM, redirect_pc, branch_cnt, mispred_cnt;
  int checks = 0, errors = 0;

  branch_resolve_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stallE(stallE), .stallM(stallM), .flushE(flushE),
    .branchD(branchD), .pred_takeD(pred_takeD), .pcD(pcD),
    .branch_targetD(branch_targetD), .actual_takeE(actual_takeE),
    .branchM(branchM), .actual_takeM(actual_takeM), .pcM(pcM),
    .pred_wrong(pred_wrong), .flush_pred(flush_pred), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst = 0; stallE = 0; stallM = 0; flushE = 0; branchD = 0; pred_takeD = 0;
    pcD = '0; branch_targetD = '0; actual_takeE = 0;
  endtask

  task automatic issue(input logic pt, input logic [31:0] pc, input logic [31:0] tgt);
    branchD = 1; pred_takeD = pt; pcD = pc; branch_targetD = tgt;
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); step(); rst = 0; #1;
    checks++; if (branchM !== 1'b0) begin errors++; $display("FAIL reset_branchM got %0b exp 0", branchM); end
    checks++; if (pred_wrong !== 1'b0 || flush_pred !== 1'b0) begin errors++; $display("FAIL reset_flags got %0b%0b exp 00", pred_wrong, flush_pred); end
    checks++; if (pcM !== RPC) begin errors++; $display("FAIL reset_pcM got %h exp %h", pcM, RPC); end
    checks++; if (redirect_pc !== RPC + 32'd8) begin errors++; $display("FAIL reset_redirect got %h exp %h", redirect_pc, RPC + 32'd8); end
    checks++; if (branch_cnt !== 0 || mispred_cnt !== 0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_correct();
    idle(); issue(1, 32'h100, 32'h180); step();
    branchD = 0; actual_takeE = 1; step();
    checks++; if (branchM !== 1 || actual_takeM !== 1 || pcM !== 32'h100) begin errors++; $display("FAIL correct_m got b%0b a%0b pc %h exp b1 a1 pc 100", branchM, actual_takeM, pcM); end
    checks++; if (pred_wrong !== 0 || flush_pred !== 0) begin errors++; $display("FAIL correct_flags got %0b%0b exp 00", pred_wrong, flush_pred); end
    checks++; if (branch_cnt !== 1 || mispred_cnt !== 0) begin errors++; $display("FAIL correct_cnt got %0d/%0d exp 1/0", branch_cnt, mispred_cnt); end
    idle(); step();
    checks++; if (branchM !== 0 || branch_cnt !== 1) begin errors++; $display("FAIL correct_drain got b%0b cnt %0d exp b0 cnt 1", branchM, branch_cnt); end
  endtask

  // predicted not-taken, taken; a new D branch during the kill cycle is discarded
  task automatic test_mispred_taken();
    idle(); issue(0, 32'h140, 32'h200); step();
    branchD = 0; actual_takeE = 1; step();
    checks++; if (pred_wrong !== 1 || flush_pred !== 1) begin errors++; $display("FAIL mt_flags got %0b%0b exp 11", pred_wrong, flush_pred); end
    checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL mt_redirect got %h exp 200", redirect_pc); end
    checks++; if (branch_cnt !== 2) begin errors++; $display("FAIL mt_bcnt got %0d exp 2", branch_cnt); end
    actual_takeE = 0; issue(1, 32'h180, 32'h280); flushE = 0; stallE = 1; step();
    checks++; if (branchM !== 0 || flush_pred !== 0 || mispred_cnt !== 1) begin errors++; $display("FAIL mt_after got b%0b f%0b m%0d exp b0 f0 m1", branchM, flush_pred, mispred_cnt); end
    idle(); step();
    checks++; if (branchM !== 0 || branch_cnt !== 2) begin errors++; $display("FAIL mt_discard got b%0b cnt %0d exp b0 cnt 2", branchM, branch_cnt); end
  endtask

  task automatic test_mispred_not_taken();
    idle(); issue(1, 32'h3FC, 32'h500); step();
    branchD = 0; actual_takeE = 0; step();
    checks++; if (pred_wrong !== 1 || redirect_pc !== 32'h404) begin errors++; $display("FAIL mn_redirect got pw%0b %h exp pw1 404", pred_wrong, redirect_pc); end
    idle(); step();
    issue(1, 32'hFFFF_FFFC, 32'h500); step();
    branchD = 0; step();
    checks++; if (pred_wrong !== 1 || redirect_pc !== 32'h4) begin errors++; $display("FAIL mn_wrap got pw%0b %h exp pw1 4", pred_wrong, redirect_pc); end
    idle(); step();
    checks++; if (branch_cnt !== 4 || mispred_cnt !== 3) begin errors++; $display("FAIL mn_cnt got %0d/%0d exp 4/3", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_stall_m();
    idle(); issue(0, 32'h600, 32'h700); step();
    branchD = 0; actual_takeE = 1; step();
    stallM = 1; actual_takeE = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pred_wrong !== 1 || flush_pred !== 0 || mispred_cnt !== 3) begin errors++; $display("FAIL sm_hold%0d got pw%0b f%0b m%0d exp pw1 f0 m3", i, pred_wrong, flush_pred, mispred_cnt); end
      step();
    end
    stallM = 0; #1;
    checks++; if (flush_pred !== 1 || redirect_pc !== 32'h700) begin errors++; $display("FAIL sm_release got f%0b %h exp f1 700", flush_pred, redirect_pc); end
    step();
    checks++; if (flush_pred !== 0 || branchM !== 0 || mispred_cnt !== 4 || branch_cnt !== 5) begin errors++; $display("FAIL sm_after got f%0b b%0b %0d/%0d exp f0 b0 5/4", flush_pred, branchM, branch_cnt, mispred_cnt); end
  endtask

  task automatic test_stall_e();
    idle(); issue(1, 32'h800, 32'h880); step();
    branchD = 0; stallE = 1; actual_takeE = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (branchM !== 0 || branch_cnt !== 5) begin errors++; $display("FAIL se_bubble%0d got b%0b cnt %0d exp b0 cnt 5", i, branchM, branch_cnt); end
    end
    stallE = 0; step();
    checks++; if (branchM !== 1 || pcM !== 32'h800 || branch_cnt !== 6 || pred_wrong !== 0) begin errors++; $display("FAIL se_release got b%0b pc %h cnt %0d pw%0b exp b1 800 6 pw0", branchM, pcM, branch_cnt, pred_wrong); end
    idle(); step();
    checks++; if (branchM !== 0 || branch_cnt !== 6) begin errors++; $display("FAIL se_once got b%0b cnt %0d exp b0 cnt 6", branchM, branch_cnt); end
  endtask

  task automatic test_flush_e();
    idle(); issue(0, 32'h900, 32'h980); flushE = 1; step();
    idle(); actual_takeE = 1; step();
    checks++; if (branchM !== 0 || pred_wrong !== 0 || branch_cnt !== 6) begin errors++; $display("FAIL fe got b%0b pw%0b cnt %0d exp b0 pw0 6", branchM, pred_wrong, branch_cnt); end
  endtask

  task automatic test_saturate_and_reset();
    idle();
    force dut.branch_cnt = 32'hFFFF_FFFF;
    force dut.mispred_cnt = 32'hFFFF_FFFF;
    step();
    release dut.branch_cnt;
    release dut.mispred_cnt;
    issue(0, 32'hA00, 32'hB00); step();
    branchD = 0; actual_takeE = 1; step();
    checks++; if (pred_wrong !== 1 || branch_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_bcnt got pw%0b %h exp pw1 ffffffff", pred_wrong, branch_cnt); end
    idle(); step();
    checks++; if (mispred_cnt !== 32'hFFFF_FFFF || branch_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_cnt got %h/%h exp ffffffff/ffffffff", branch_cnt, mispred_cnt); end
    issue(1, 32'hC00, 32'hD00); step();
    branchD = 0; actual_takeE = 0; step();
    stallM = 1; issue(1, 32'hE00, 32'hF00); step();
    rst = 1; step();
    checks++; if (branchM !== 0 || actual_takeM !== 0 || pred_wrong !== 0 || flush_pred !== 0) begin errors++; $display("FAIL rst_flags got b%0b a%0b pw%0b f%0b exp 0000", branchM, actual_takeM, pred_wrong, flush_pred); end
    checks++; if (branch_cnt !== 0 || mispred_cnt !== 0) begin errors++; $display("FAIL rst_cnt got %h/%h exp 0/0", branch_cnt, mispred_cnt); end
    checks++; if (pcM !== RPC || redirect_pc !== RPC + 32'd8) begin errors++; $display("FAIL rst_pc got %h %h exp %h %h", pcM, redirect_pc, RPC, RPC + 32'd8); end
    idle(); step(); step();
    checks++; if (branchM !== 0 || branch_cnt !== 0) begin errors++; $display("FAIL rst_e_cleared got b%0b cnt %0d exp b0 cnt 0", branchM, branch_cnt); end
  endtask

  initial begin
    idle();
    test_reset();
    test_correct();
    test_mispred_taken();
    test_mispred_not_taken();
    test_stall_m();
    test_stall_e();
    test_flush_e();
    test_saturate_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the value loaded into the pc pipeline registers on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports stallE and stallM, each input, 1 bit: hold the E and M stage registers, respectively.
REQ-005 SHALL have port flushE, input, 1 bit: external bubble into the E stage.
REQ-006 SHALL have ports branchD and pred_takeD, each input, 1 bit: D-stage branch flag and the predictor's taken prediction.
REQ-007 SHALL have ports pcD and branch_targetD, each input, 32 bits: D-stage branch PC and taken target.
REQ-008 SHALL have port actual_takeE, input, 1 bit: the E-stage resolved branch outcome.
REQ-009 SHALL have ports branchM and actual_takeM, each output, 1 bit: the M-stage branch flag and its resolved outcome.
REQ-010 SHALL have port pcM, output, 32 bits: the M-stage branch PC.
REQ-011 SHALL have port pred_wrong, output, 1 bit: the M-stage branch was mispredicted.
REQ-012 SHALL have port flush_pred, output, 1 bit: kill the wrong-path instructions in F, D and E.
REQ-013 SHALL have port redirect_pc, output, 32 bits: the corrected fetch PC.
REQ-014 SHALL have ports branch_cnt and mispred_cnt, each output, 32 bits: statistics counters.

Function
REQ-015 SHALL register D->E fields {branch, pred_take, pc, target} each cycle ~stallE holds, with priority rst > kill > flushE > stallE; a bubble clears branch and pred_take and leaves pc/target don't-care.
REQ-016 SHALL register E->M fields {branch, pred_take, actual_take=actual_takeE, pc, target} each cycle ~stallM holds, with priority rst > kill > stallM.
REQ-017 SHALL load a bubble into M whenever stallE=1 and stallM=0, so that an E instruction never enters M twice.
REQ-018 SHALL define kill = pred_wrong & ~stallM; kill forces bubbles into both the E and M registers on the next edge, overriding stalls.
REQ-019 SHALL compute pred_wrong = branchM & (pred_takeM != actual_takeM) combinationally from the M registers.
REQ-020 SHALL drive flush_pred = kill, asserted for exactly one cycle per mispredicted branch.
REQ-021 SHALL drive redirect_pc = actual_takeM ? targetM : pcM + 8 (delay slot skipped), with 32-bit addition wrapping modulo 2^32; the value is meaningful only while pred_wrong=1.
REQ-022 SHALL increment branch_cnt once per branch loaded into M (~stallM, not kill, branchE=1), counting stalled cycles only once.
REQ-023 SHALL increment mispred_cnt once per kill.
REQ-024 SHALL saturate both counters at 32'hFFFF_FFFF with no wrap.
REQ-025 SHALL hold pred_wrong asserted, with flush_pred=0, while stallM=1 with a mispredicted branch in M; flush_pred asserts in the first cycle in which stallM=0.
REQ-026 SHALL let kill override a simultaneous flushE or stallE; a new branch in D during the kill cycle is discarded.

Reset
REQ-027 SHALL clear, on rst at any clk edge (including mid-stall or mid-kill), all stage flags, both counters and all outputs to 0, and set pcM and the E pc to RESET_PC, with redirect_pc = RESET_PC+8 after reset.

Verification
REQ-028 SHALL pass this case: correct prediction, branchD=1, pred_takeD=1, pcD=0x100, actual_takeE=1 -> branchM=1 two edges later, pred_wrong=0, branch_cnt=1, mispred_cnt=0.
REQ-029 SHALL pass this case: predicted not-taken, actually taken, target=0x200 -> pred_wrong=1, flush_pred=1 for one cycle, redirect_pc=0x200, branchM=0 next cycle, mispred_cnt=1.
REQ-030 SHALL pass this case: predicted taken, actually not-taken, pcD=0x3FC -> redirect_pc=0x404; with pcD=0xFFFFFFFC -> redirect_pc=0x4.
REQ-031 SHALL pass this case: mispredict in M with stallM=1 for 3 cycles -> pred_wrong=1 and flush_pred=0 for 3 cycles, then flush_pred=1 for 1 cycle, mispred_cnt=1, branch_cnt=1.
REQ-032 SHALL pass this case: stallE=1, stallM=0 with a branch in E for 2 cycles -> a bubble enters M, and branch_cnt increments once after the stall releases.
REQ-033 SHALL pass this case: counters preloaded to 0xFFFFFFFF, then a further mispredicted branch -> both counters remain 0xFFFFFFFF; rst asserted -> all outputs 0 next edge.
